// File: rtl/rca_seq_ctrl_if.sv
// Operand/result bundle for rca_seq_ctrl.
//   master: drives start/a/b, observes busy/done/result (operand source side)
//   slave : the sequencer itself
interface rca_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   result;

  modport master (output start, a, b, input  busy, done, result);
  modport slave  (input  start, a, b, output busy, done, result);
endinterface

// File: rtl/rca_seq_ctrl.sv
// Multi-cycle adder: sums two WIDTH-bit operands through a CHUNK-bit ripple-carry
// adder, one chunk per clock, LSB chunk first, carry held in a register between chunks.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous reset, active low
//   bus    slave side of rca_seq_ctrl_if: start/a/b in, busy/done/result out
//          (result[WIDTH] is the final carry out; valid while done=1 and held afterwards)
module rca_seq_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  rca_seq_ctrl_if.slave bus
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IDXW-1:0]  idx, idx_nxt;
  logic             carry, carry_nxt;
  logic [WIDTH-1:0] a_r, a_nxt;
  logic [WIDTH-1:0] b_r, b_nxt;
  logic [WIDTH:0]   result_r, result_nxt;
  logic             busy_r, done_r;

  logic [31:0]      base_c;
  logic [CHUNK:0]   sum_c;
  logic             last_c;

  // Bit-level ripple-carry adder for one chunk; carry-in folds in the inter-chunk carry.
  function automatic logic [CHUNK:0] rca(input logic [CHUNK-1:0] x,
                                         input logic [CHUNK-1:0] y,
                                         input logic             cin);
    logic             c;
    logic [CHUNK-1:0] s;
    c = cin;
    s = '0;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  // Current chunk slice and its sum.
  assign base_c = 32'(idx) * 32'(CHUNK);
  assign sum_c  = rca(a_r[base_c +: CHUNK], b_r[base_c +: CHUNK], carry);
  assign last_c = (idx == IDXW'(NCHUNK - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and datapath next values.
  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    carry_nxt  = carry;
    a_nxt      = a_r;
    b_nxt      = b_r;
    result_nxt = result_r;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          a_nxt      = bus.a;
          b_nxt      = bus.b;
          idx_nxt    = '0;
          carry_nxt  = 1'b0;
          result_nxt = '0;
          state_nxt  = S_RUN;
        end else if (state == S_DONE) begin
          state_nxt  = S_IDLE;
        end
      end
      S_RUN: begin
        result_nxt[base_c +: CHUNK] = sum_c[CHUNK-1:0];
        carry_nxt                   = sum_c[CHUNK];
        if (last_c) begin
          result_nxt[WIDTH] = sum_c[CHUNK];
          state_nxt         = S_DONE;
        end else begin
          idx_nxt = idx + IDXW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath and registered status; busy/done track the state being entered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx      <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      result_r <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      idx      <= idx_nxt;
      carry    <= carry_nxt;
      a_r      <= a_nxt;
      b_r      <= b_nxt;
      result_r <= result_nxt;
      busy_r   <= (state_nxt == S_RUN);
      done_r   <= (state_nxt == S_DONE);
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.result = result_r;

endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Bench for rca_seq_ctrl: stimulus pushes expected sums and their done cycle into a
// queue; a negedge monitor checks busy/done timing and result against that queue.
module tb_rca_seq_ctrl;

  localparam int N = 4;  // 32/8 chunks

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rca_seq_ctrl_if #(.WIDTH(32)) bus ();
  rca_seq_ctrl_if #(.WIDTH(8))  bus8 ();

  rca_seq_ctrl #(.WIDTH(32), .CHUNK(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  rca_seq_ctrl #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus8)
  );

  typedef struct {
    logic [32:0] sum;
    int          done_edge;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] last_exp = '0;
  int          ecount = 0;
  int          reset_edge = 1;
  int          next_free = 0;
  int          n_ops = 0;
  int          n_vec = 0;
  int          n_err = 0;

  always @(posedge clk) ecount <= ecount + 1;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", name, ecount, act, req);
    end
  endtask

  // Monitor: the interval after edge ecount.
  always @(negedge clk) begin
    if (ecount >= 1) begin
      logic busy_exp;
      logic done_exp;
      if (ecount == reset_edge) begin
        exp_q.delete();
        last_exp = '0;
      end
      busy_exp = 1'b0;
      foreach (exp_q[i])
        if (ecount >= exp_q[i].done_edge - N && ecount < exp_q[i].done_edge) busy_exp = 1'b1;
      done_exp = (exp_q.size() > 0) && (exp_q[0].done_edge == ecount);
      cmp("busy", 64'(bus.busy), 64'(busy_exp));
      cmp("done", 64'(bus.done), 64'(done_exp));
      if (done_exp) begin
        last_exp = exp_q[0].sum;
        void'(exp_q.pop_front());
      end
      if (!busy_exp) cmp("result", 64'(bus.result), 64'(last_exp));
    end
  end

  // Apply inputs for the next edge; record an expected op if the sequencer is free then.
  task automatic drive(input logic s, input logic [31:0] av, input logic [31:0] bv);
    exp_t e;
    bus.start = s;
    bus.a     = av;
    bus.b     = bv;
    if (s && (ecount + 1 >= next_free)) begin
      e.sum       = 33'(av) + 33'(bv);
      e.done_edge = ecount + 1 + N;
      exp_q.push_back(e);
      next_free = ecount + 2 + N;
      n_ops++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_edge = ecount + 1;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus8.start = 1'b0;
    @(posedge clk); #1;
    rst_n     = 1'b1;
    next_free = 0;
  endtask

  initial begin
    logic [7:0] t8a[3];
    logic [7:0] t8b[3];
    int         ops_target;

    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1'b0, 32'h0, 32'h0);

    // Full carry ripple, then a few directed sums.
    drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0001);
    repeat (6) drive(1'b0, $urandom, $urandom);
    drive(1'b1, 32'h1234_5678, 32'h1111_1111);
    repeat (5) drive(1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'h8000_0000, 32'h8000_0000);
    repeat (5) drive(1'b0, 32'h0, 32'h0);

    // start held high 12 cycles, operands toggled while the sequencer is busy.
    for (int i = 0; i < 12; i++) begin
      if (i == 0 || i == 5 || i == 10) drive(1'b1, 32'd1, 32'd2);
      else                             drive(1'b1, $urandom, $urandom);
    end
    repeat (6) drive(1'b0, 32'h0, 32'h0);

    // Reset in the middle of RUN, then a normal op.
    drive(1'b1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    drive(1'b0, $urandom, $urandom);
    drive(1'b0, $urandom, $urandom);
    do_reset();
    repeat (3) drive(1'b0, 32'h0, 32'h0);
    drive(1'b1, 32'hCAFE_0001, 32'h0000_FFFF);
    repeat (6) drive(1'b0, 32'h0, 32'h0);

    // Single-chunk configuration.
    t8a[0] = 8'hFF; t8b[0] = 8'hFF;
    t8a[1] = 8'h01; t8b[1] = 8'hFE;
    t8a[2] = 8'h80; t8b[2] = 8'h80;
    for (int i = 0; i < 3; i++) begin
      bus8.start = 1'b1; bus8.a = t8a[i]; bus8.b = t8b[i];
      @(posedge clk); #1;
      bus8.start = 1'b0; bus8.a = ~t8a[i];
      cmp("w8_busy_run", 64'(bus8.busy), 64'd1);
      cmp("w8_done_run", 64'(bus8.done), 64'd0);
      @(posedge clk); #1;
      cmp("w8_done", 64'(bus8.done), 64'd1);
      cmp("w8_busy_done", 64'(bus8.busy), 64'd0);
      cmp("w8_result", 64'(bus8.result), 64'(9'(t8a[i]) + 9'(t8b[i])));
      @(posedge clk); #1;
      cmp("w8_done_idle", 64'(bus8.done), 64'd0);
      cmp("w8_result_hold", 64'(bus8.result), 64'(9'(t8a[i]) + 9'(t8b[i])));
    end

    // Random traffic with random gaps; back-to-back arises when start is high in DONE.
    ops_target = n_ops + 1000;
    while (n_ops < ops_target)
      drive(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0, $urandom, $urandom);

    // Drain with a bounded wait.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) drive(1'b0, 32'h0, 32'h0);
    drive(1'b0, 32'h0, 32'h0);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d ops still pending, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
